// File: rtl/if_stage_pkg.sv
// Shared encodings and defaults for the RV32I instruction-fetch stage.
// The optional counter block is enabled by defining IF_STAGE_PERF_EN.
package if_stage_pkg;

    typedef enum logic [1:0] {
        NPC_PC4  = 2'd0,
        NPC_BEQ  = 2'd1,
        NPC_JMP  = 2'd2,
        NPC_JMPR = 2'd3
    } npc_op_t;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          IROM_AW_DEF  = 14;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bus bundle between the fetch stage and the rest of the pipeline.
// Counter outputs exist only when IF_STAGE_PERF_EN is defined.
interface if_stage_if #(
    parameter int IROM_AW = 14
);
    logic               stall;
    logic               ex_valid;
    logic [1:0]         ex_npc_op;
    logic               ex_br_taken;
    logic [31:0]        ex_pc;
    logic [31:0]        ex_imm;
    logic [31:0]        ex_alu_c;
    logic [IROM_AW-1:0] irom_addr;
    logic [31:0]        irom_inst;
    logic               redirect;
    logic [31:0]        id_pc;
    logic [31:0]        id_pc4;
    logic [31:0]        id_inst;
    logic               id_valid;
`ifdef IF_STAGE_PERF_EN
    logic [31:0]        perf_fetch_cnt;
    logic [31:0]        perf_flush_cnt;
`endif

    // Pipeline/ROM side: drives EX control and ROM data, consumes IF/ID.
    modport master (
`ifdef IF_STAGE_PERF_EN
        input  perf_fetch_cnt,
        input  perf_flush_cnt,
`endif
        output stall, ex_valid, ex_npc_op, ex_br_taken, ex_pc, ex_imm, ex_alu_c,
        output irom_inst,
        input  irom_addr, redirect, id_pc, id_pc4, id_inst, id_valid
    );

    modport slave (
`ifdef IF_STAGE_PERF_EN
        output perf_fetch_cnt,
        output perf_flush_cnt,
`endif
        input  stall, ex_valid, ex_npc_op, ex_br_taken, ex_pc, ex_imm, ex_alu_c,
        input  irom_inst,
        output irom_addr, redirect, id_pc, id_pc4, id_inst, id_valid
    );

endinterface

// File: rtl/if_stage_npc.sv
// Next-PC resolution: decides whether the EX-stage instruction redirects fetch
// and where to. Purely combinational.
module if_stage_npc
    import if_stage_pkg::*;
(
    input  logic        ex_valid,
    input  logic [1:0]  ex_npc_op,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_alu_c,
    output logic        redirect,
    output logic [31:0] target
);

    npc_op_t op;
    logic    taken;

    assign op = npc_op_t'(ex_npc_op);

    always_comb begin
        taken  = 1'b0;
        target = ex_pc + ex_imm;
        case (op)
            NPC_BEQ:  taken = ex_br_taken;
            NPC_JMP:  taken = 1'b1;
            NPC_JMPR: begin
                taken  = 1'b1;
                // jalr clears only bit 0; bit 1 is left for the ROM to ignore
                target = ex_alu_c & ~32'h1;
            end
            default:  taken = 1'b0;
        endcase
    end

    assign redirect = ex_valid & taken;

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC register, ROM addressing and IF/ID latch.
// Define IF_STAGE_PERF_EN to add fetch/flush event counters.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          IROM_AW  = IROM_AW_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input logic          cpu_clk,
    input logic          cpu_rst,
    if_stage_if.slave    bus
);

    logic [31:0] pc_p0;
    logic [31:0] id_pc_p1;
    logic [31:0] id_pc4_p1;
    logic [31:0] id_inst_p1;
    logic        vld_p1;
    logic        redirect;
    logic [31:0] target;

    if_stage_npc u_npc (
        .ex_valid    (bus.ex_valid),
        .ex_npc_op   (bus.ex_npc_op),
        .ex_br_taken (bus.ex_br_taken),
        .ex_pc       (bus.ex_pc),
        .ex_imm      (bus.ex_imm),
        .ex_alu_c    (bus.ex_alu_c),
        .redirect    (redirect),
        .target      (target)
    );

    // Stage p0 -> p1: PC update and IF/ID latch; redirect outranks stall
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            pc_p0      <= RESET_PC;
            id_pc_p1   <= 32'h0;
            id_pc4_p1  <= 32'h0;
            id_inst_p1 <= NOP_INST;
            vld_p1     <= 1'b0;
        end else if (redirect) begin
            pc_p0      <= target;
            id_inst_p1 <= NOP_INST;
            vld_p1     <= 1'b0;
        end else if (!bus.stall) begin
            pc_p0      <= pc_plus4(pc_p0);
            id_pc_p1   <= pc_p0;
            id_pc4_p1  <= pc_plus4(pc_p0);
            id_inst_p1 <= bus.irom_inst;
            vld_p1     <= 1'b1;
        end
    end

`ifdef IF_STAGE_PERF_EN
    logic [31:0] fetch_cnt_p1;
    logic [31:0] flush_cnt_p1;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            fetch_cnt_p1 <= 32'h0;
            flush_cnt_p1 <= 32'h0;
        end else if (redirect) begin
            flush_cnt_p1 <= flush_cnt_p1 + 32'd1;
        end else if (!bus.stall) begin
            fetch_cnt_p1 <= fetch_cnt_p1 + 32'd1;
        end
    end

    assign bus.perf_fetch_cnt = fetch_cnt_p1;
    assign bus.perf_flush_cnt = flush_cnt_p1;
`endif

    assign bus.irom_addr = pc_p0[IROM_AW+1:2];
    assign bus.redirect  = redirect;
    assign bus.id_pc     = id_pc_p1;
    assign bus.id_pc4    = id_pc4_p1;
    assign bus.id_inst   = id_inst_p1;
    assign bus.id_valid  = vld_p1;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// against a behavioural fetch model. Covers counters when IF_STAGE_PERF_EN is set.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    // Behavioural model of the architectural state
    logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_inst;
    logic        m_id_valid;
    logic [31:0] m_fetch, m_flush;

    if_stage_if #(.IROM_AW(14)) bus ();

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .IROM_AW  (14),
        .NOP_INST (NOP)
    ) dut (
        .cpu_clk (clk),
        .cpu_rst (rst),
        .bus     (bus.slave)
    );

    function automatic logic [31:0] rom_word(input logic [13:0] a);
        if (a == 14'd0) return 32'h0050_0093;
        return ({18'h0, a} * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    assign bus.irom_inst = rom_word(bus.irom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_taken();
        return bus.ex_valid && (bus.ex_npc_op == 2'd2 || bus.ex_npc_op == 2'd3 ||
                                (bus.ex_npc_op == 2'd1 && bus.ex_br_taken));
    endfunction

    function automatic logic [31:0] model_target();
        if (bus.ex_npc_op == 2'd3) return {bus.ex_alu_c[31:1], 1'b0};
        return bus.ex_pc + bus.ex_imm;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_id_pc = 32'h0; m_id_pc4 = 32'h0;
        m_id_inst = NOP; m_id_valid = 1'b0; m_fetch = 32'h0; m_flush = 32'h0;
    endtask

    task automatic set_idle();
        bus.stall = 1'b0; bus.ex_valid = 1'b0; bus.ex_npc_op = 2'd0;
        bus.ex_br_taken = 1'b0; bus.ex_pc = 32'h0; bus.ex_imm = 32'h0; bus.ex_alu_c = 32'h0;
    endtask

    // One clock edge; the model consumes the inputs the DUT sees at that edge
    task automatic tick();
        if (model_taken()) begin
            m_pc = model_target(); m_id_inst = NOP; m_id_valid = 1'b0; m_flush++;
        end else if (!bus.stall) begin
            m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4;
            m_id_inst = rom_word(m_pc[15:2]); m_id_valid = 1'b1;
            m_pc = m_pc + 32'd4; m_fetch++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (bus.irom_addr !== 14'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.irom_addr); end
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.id_valid); end
        checks++; if (bus.id_pc !== 32'h0 || bus.id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h/%h want 0/0", bus.id_pc, bus.id_pc4); end
        rst = 1'b0;
        #1;
        checks++; if (bus.id_inst !== NOP) begin errors++; $display("FAIL reset_inst: got %h want %h", bus.id_inst, NOP); end
    endtask

    task automatic test_first_fetch();
        tick();
        checks++; if (bus.id_pc !== 32'h0 || bus.id_pc4 !== 32'h4) begin errors++; $display("FAIL fetch0_pc: got %h/%h want 0/4", bus.id_pc, bus.id_pc4); end
        checks++; if (bus.id_inst !== 32'h0050_0093 || bus.id_valid !== 1'b1) begin errors++; $display("FAIL fetch0_inst: got %h v%b want 00500093 v1", bus.id_inst, bus.id_valid); end
        tick();
        checks++; if (bus.irom_addr !== 14'd2) begin errors++; $display("FAIL fetch1_addr: got %h want 2", bus.irom_addr); end
    endtask

    task automatic test_stall();
        tick(); tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.irom_addr !== 14'd4 || bus.id_pc !== 32'hC || bus.id_pc4 !== 32'h10 ||
                bus.id_inst !== rom_word(14'd3) || bus.id_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: got addr %h pc %h inst %h v%b want 4 c %h v1",
                         bus.irom_addr, bus.id_pc, bus.id_inst, bus.id_valid, rom_word(14'd3));
            end
        end
        bus.stall = 1'b0;
        tick();
        checks++; if (bus.id_pc !== 32'h10 || bus.id_inst !== rom_word(14'd4)) begin errors++; $display("FAIL stall_release: got %h/%h want 10/%h", bus.id_pc, bus.id_inst, rom_word(14'd4)); end
    endtask

    task automatic test_branch();
        bus.ex_valid = 1'b1; bus.ex_npc_op = 2'd1; bus.ex_br_taken = 1'b1;
        bus.ex_pc = 32'h20; bus.ex_imm = 32'hFFFF_FFF8;
        #1;
        checks++; if (bus.redirect !== 1'b1) begin errors++; $display("FAIL beq_taken_redirect: got %b want 1", bus.redirect); end
        tick();
        checks++; if (bus.irom_addr !== 14'h6 || bus.id_valid !== 1'b0 || bus.id_inst !== NOP || bus.id_pc !== 32'h10) begin
            errors++; $display("FAIL beq_taken_state: got addr %h v%b inst %h pc %h want 6 v0 13 10", bus.irom_addr, bus.id_valid, bus.id_inst, bus.id_pc); end
        bus.ex_br_taken = 1'b0;
        #1;
        checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL beq_nt_redirect: got %b want 0", bus.redirect); end
        tick();
        checks++; if (bus.irom_addr !== 14'h7 || bus.id_pc !== 32'h18 || bus.id_valid !== 1'b1) begin
            errors++; $display("FAIL beq_nt_state: got addr %h pc %h v%b want 7 18 v1", bus.irom_addr, bus.id_pc, bus.id_valid); end
        bus.ex_valid = 1'b0; bus.ex_npc_op = 2'd2;
        #1;
        checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL exinvalid_redirect: got %b want 0", bus.redirect); end
        tick();
        checks++; if (bus.irom_addr !== 14'h8) begin errors++; $display("FAIL exinvalid_pc: got %h want 8", bus.irom_addr); end
        set_idle();
    endtask

    task automatic test_jmpr_stall();
        bus.ex_valid = 1'b1; bus.ex_npc_op = 2'd3; bus.ex_alu_c = 32'h0000_0105; bus.stall = 1'b1;
        #1;
        checks++; if (bus.redirect !== 1'b1) begin errors++; $display("FAIL jmpr_redirect: got %b want 1", bus.redirect); end
        tick();
        checks++; if (bus.irom_addr !== 14'h41 || bus.id_valid !== 1'b0 || bus.id_inst !== NOP) begin
            errors++; $display("FAIL jmpr_stall_state: got addr %h v%b inst %h want 41 v0 13", bus.irom_addr, bus.id_valid, bus.id_inst); end
        set_idle();
        tick();
        checks++; if (bus.id_pc !== 32'h104 || bus.id_pc4 !== 32'h108) begin errors++; $display("FAIL jmpr_target: got %h/%h want 104/108", bus.id_pc, bus.id_pc4); end
    endtask

    task automatic test_wrap();
        bus.ex_valid = 1'b1; bus.ex_npc_op = 2'd3; bus.ex_alu_c = 32'hFFFF_FFFC;
        tick();
        set_idle();
        checks++; if (bus.irom_addr !== 14'h3FFF) begin errors++; $display("FAIL wrap_top: got %h want 3fff", bus.irom_addr); end
        tick();
        checks++; if (bus.irom_addr !== 14'h0 || bus.id_pc !== 32'hFFFF_FFFC || bus.id_pc4 !== 32'h0) begin
            errors++; $display("FAIL wrap_zero: got addr %h pc %h pc4 %h want 0 fffffffc 0", bus.irom_addr, bus.id_pc, bus.id_pc4); end
`ifdef IF_STAGE_PERF_EN
        checks++; if (bus.perf_fetch_cnt !== m_fetch || bus.perf_flush_cnt !== m_flush) begin
            errors++; $display("FAIL perf_counts: got %0d/%0d want %0d/%0d", bus.perf_fetch_cnt, bus.perf_flush_cnt, m_fetch, m_flush); end
`endif
    endtask

    task automatic test_reset_mid_redirect();
        bus.ex_valid = 1'b1; bus.ex_npc_op = 2'd2; bus.ex_pc = 32'h40; bus.ex_imm = 32'h0;
        tick();
        checks++; if (bus.irom_addr !== 14'h10) begin errors++; $display("FAIL mid_setup: got %h want 10", bus.irom_addr); end
        bus.ex_pc = 32'h100; bus.ex_imm = 32'h20;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (bus.irom_addr !== 14'h0 || bus.id_valid !== 1'b0 || bus.id_inst !== NOP || bus.id_pc !== 32'h0) begin
            errors++; $display("FAIL mid_reset: got addr %h v%b inst %h pc %h want 0 v0 13 0", bus.irom_addr, bus.id_valid, bus.id_inst, bus.id_pc); end
`ifdef IF_STAGE_PERF_EN
        checks++; if (bus.perf_fetch_cnt !== 32'h0 || bus.perf_flush_cnt !== 32'h0) begin
            errors++; $display("FAIL mid_reset_perf: got %0d/%0d want 0/0", bus.perf_fetch_cnt, bus.perf_flush_cnt); end
`endif
        @(posedge clk); #1;
        checks++; if (bus.irom_addr !== 14'h0) begin errors++; $display("FAIL reset_holds: got %h want 0", bus.irom_addr); end
        set_idle();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.stall       = ($urandom_range(0, 3) == 0);
            bus.ex_valid    = ($urandom_range(0, 3) != 0);
            bus.ex_npc_op   = 2'($urandom_range(0, 3));
            bus.ex_br_taken = $urandom_range(0, 1) == 1;
            bus.ex_pc       = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            bus.ex_imm      = {$urandom, 1'b0} ;
            bus.ex_alu_c    = $urandom;
            // Favour short, mostly-straight runs so sequential fetch is exercised too
            if ($urandom_range(0, 2) != 0) bus.ex_npc_op = 2'd0;
            #1;
            checks++;
            if (bus.redirect !== model_taken()) begin
                errors++; $display("FAIL rand_redirect[%0d]: got %b want %b", i, bus.redirect, model_taken()); end
            tick();
            checks++;
            if (bus.irom_addr !== m_pc[15:2] || bus.id_pc !== m_id_pc || bus.id_pc4 !== m_id_pc4 ||
                bus.id_inst !== m_id_inst || bus.id_valid !== m_id_valid) begin
                errors++;
                $display("FAIL rand_state[%0d]: got addr %h pc %h pc4 %h inst %h v%b want %h %h %h %h v%b", i,
                         bus.irom_addr, bus.id_pc, bus.id_pc4, bus.id_inst, bus.id_valid,
                         m_pc[15:2], m_id_pc, m_id_pc4, m_id_inst, m_id_valid);
            end
`ifdef IF_STAGE_PERF_EN
            checks++;
            if (bus.perf_fetch_cnt !== m_fetch || bus.perf_flush_cnt !== m_flush) begin
                errors++; $display("FAIL rand_perf[%0d]: got %0d/%0d want %0d/%0d", i, bus.perf_fetch_cnt, bus.perf_flush_cnt, m_fetch, m_flush); end
`endif
        end
        set_idle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        set_idle();
        test_reset();
        test_first_fetch();
        test_stall();
        test_branch();
        test_jmpr_stall();
        test_wrap();
        test_reset_mid_redirect();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
